sid_bus_regs: RTL
=================

SID_BUS_REGS -- requirements
Module: sid_bus_regs

Interface
REQ-001 Parameter N_SIDS, default 2: number of SID register banks (1..4).
REQ-002 Parameter TTL_MOS6581, default 20'h01D00: PHI2 strobes until the bus value fades out, 6581.
REQ-003 Parameter TTL_MOS8580, default 20'hA2000: PHI2 strobes until the bus value fades out, 8580.
REQ-004 clk  in  1  system clock; the single clock for all logic.
REQ-005 res_n  in  1  reset, synchronous, active-low.
REQ-006 model  in  N_SIDS  per-bank model; 0 = MOS6581, 1 = MOS8580.
REQ-007 phi2  in  1  one-clk strobe marking the PHI2 bus-commit point.
REQ-008 cs  in  N_SIDS  per-bank chip select.
REQ-009 oe  in  1  bus read enable.
REQ-010 we  in  1  bus write enable.
REQ-011 addr  in  5  register address 0x00..0x1F.
REQ-012 data_i  in  8  write data.
REQ-013 data_o  out  8  read data, registered.
REQ-014 ro_regs  in  N_SIDS*32  per bank {ENV3,OSC3,POTY,POTX}; bank k occupies bits [32k+31:32k].
REQ-015 wo_regs  out  N_SIDS*200  per bank write-only registers 0x00..0x18; byte a of bank k at bits [200k+8a+7:200k+8a].
REQ-016 cs_err  out  1  registered flag: more than one cs bit set at the last phi2.

Function
REQ-017 Select is valid only when exactly one cs bit is set; the selected bank is s.
REQ-018 Read hit: valid select, oe=1, addr in 0x19..0x1C.
REQ-019 Write hit: valid select, we=1, addr <= 0x18; writes to 0x19..0x1F are ignored for register storage.
REQ-020 data_o updates every clk, latency 1: read hit -> ro_regs byte (addr-0x19) of bank s; otherwise valid select -> bus_value[s]; otherwise 0.
REQ-021 Register writes commit only on clk edges with phi2=1.
REQ-022 Each bank keeps bus_value (8 bit) and bus_age (20 bit); they update only on phi2=1 clk edges.
REQ-023 On a phi2 read hit for bank s: bus_value[s] <= current data_o; bus_age[s] <= 0.
REQ-024 On a phi2 write for bank s, including 0x19..0x1F: bus_value[s] <= data_i; bus_age[s] <= 0.
REQ-025 Otherwise, when bus_age == TTL for the bank's model, bus_value <= 0 and bus_age holds; when below TTL, bus_age increments.
REQ-026 Unselected banks keep fading independently.
REQ-027 A model change mid-fade applies the new TTL at once; if bus_age > new TTL, the bank clears on the next phi2 and bus_age reloads to the new TTL.
REQ-028 On phi2 with multiple cs bits set: no bank changes register or bus state; all banks keep fading; cs_err <= 1.
REQ-029 On phi2 with valid or empty select: cs_err <= 0.
REQ-030 oe and we both set on a hit: write takes precedence for the bus latch; data_o still follows REQ-020.

Reset
REQ-031 When res_n=0 at a clk edge, regardless of phi2: all wo_regs, bus_value and bus_age <= 0; data_o <= 0; cs_err <= 0.
REQ-032 Reset releases on the first clk edge with res_n=1; no partial write from the reset cycle survives.

Configuration
REQ-033 SID_REG_READBACK_EN defined: a read with valid select, oe=1 and addr <= 0x18 returns the stored wo_regs byte of bank s (latency 1) and latches it per REQ-023.
REQ-034 SID_REG_READBACK_EN undefined: such a read returns bus_value[s], as on real silicon.

Structure
REQ-035 Package sid holds: model encoding, register-count constants (25 write-only, 4 read-only), read-only base address 0x19, and TTL defaults.
REQ-036 One sub-module, sid_bus_fade, instantiated once per bank, holds bus_value/bus_age and the TTL selection; the top holds select decode, the register arrays and the data_o mux.

Verification
REQ-037 Reset, then write 0x55 to bank0 reg 0x04 on phi2 -> wo_regs bank0 byte4 = 0x55; bank1 unchanged (0).
REQ-038 Read bank1 0x1B with ro_regs OSC3 = 0xA7 -> data_o = 0xA7 one clk later; after phi2, non-hit read of bank1 0x00 returns 0xA7.
REQ-039 6581 bank: write 0x3C, then 0x01D00 idle phi2 -> value still 0x3C; on the 0x01D01st -> 0x00.
REQ-040 cs=2'b11 with we=1, data 0xFF, addr 0x00 on phi2 -> no register change; cs_err=1; next valid phi2 -> cs_err=0.
REQ-041 Reset asserted mid-fade without phi2 -> bus_value and data_o = 0 on the next clk.
REQ-042 Read of addr 0x02 after writing 0x12 there -> 0x12 with SID_REG_READBACK_EN; the faded bus value without it.

Source files
------------

// File: rtl/sid_bus_regs_pkg.sv
// Shared constants for the SID bus register slice: model encoding, register counts,
// read-only base address and default bus fade times.
package sid_bus_regs_pkg;

    typedef enum logic {
        Mos6581 = 1'b0,
        Mos8580 = 1'b1
    } sid_model_e;

    localparam int unsigned NumWoRegs     = 25;
    localparam int unsigned NumRoRegs     = 4;
    localparam logic [4:0]  RoBase        = 5'h19;
    localparam logic [19:0] TtlMos6581Def = 20'h01D00;
    localparam logic [19:0] TtlMos8580Def = 20'hA2000;

endpackage

// File: rtl/sid_bus_fade.sv
// Per-bank floating data-bus latch: holds the last bus value and clears it after the
// model-dependent number of PHI2 strobes without bus activity.
module sid_bus_fade
    import sid_bus_regs_pkg::*;
#(
    parameter logic [19:0] TTL_MOS6581 = TtlMos6581Def,
    parameter logic [19:0] TTL_MOS8580 = TtlMos8580Def
) (
    input  logic       clk,
    input  logic       res_n,
    input  logic       phi2,
    input  logic       model,
    input  logic       load,
    input  logic [7:0] load_value,
    output logic [7:0] bus_value
);

    logic [19:0] bus_age;
    logic [19:0] ttl;

    assign ttl = (sid_model_e'(model) == Mos8580) ? TTL_MOS8580 : TTL_MOS6581;

    always_ff @(posedge clk) begin
        if (!res_n) begin
            bus_value <= '0;
            bus_age   <= '0;
        end else if (phi2) begin
            if (load) begin
                bus_value <= load_value;
                bus_age   <= '0;
            end else if (bus_age >= ttl) begin
                // Age above TTL happens after a model switch; snap back to the new TTL.
                bus_value <= '0;
                bus_age   <= ttl;
            end else begin
                bus_age <= bus_age + 20'd1;
            end
        end
    end

endmodule

// File: rtl/sid_bus_regs.sv
// SID register banks: chip-select decode, write-only register storage, read mux and
// per-bank bus fade. Optional macro SID_REG_READBACK_EN makes write-only registers readable.
module sid_bus_regs
    import sid_bus_regs_pkg::*;
#(
    parameter int unsigned N_SIDS      = 2,
    parameter logic [19:0] TTL_MOS6581 = TtlMos6581Def,
    parameter logic [19:0] TTL_MOS8580 = TtlMos8580Def
) (
    input  logic                  clk,
    input  logic                  res_n,
    input  logic [N_SIDS-1:0]     model,
    input  logic                  phi2,
    input  logic [N_SIDS-1:0]     cs,
    input  logic                  oe,
    input  logic                  we,
    input  logic [4:0]            addr,
    input  logic [7:0]            data_i,
    output logic [7:0]            data_o,
    input  logic [N_SIDS*32-1:0]  ro_regs,
    output logic [N_SIDS*200-1:0] wo_regs,
    output logic                  cs_err
);

    localparam int unsigned IdxW = (N_SIDS > 1) ? $clog2(N_SIDS) : 1;

    logic [7:0]      regs     [N_SIDS][NumWoRegs];
    logic [7:0]      ro_bytes [N_SIDS][NumRoRegs];
    logic [7:0]      bus_vals [N_SIDS];
    logic [IdxW-1:0] sel_idx;
    logic [2:0]      sel_count;
    logic            sel_valid, sel_multi;
    logic            addr_ro, addr_wo;
    logic            read_hit, wr_en, rd_back, latch_rd;
    logic [1:0]      ro_sub;
    logic [7:0]      data_d;

    always_comb begin
        sel_idx   = '0;
        sel_count = '0;
        for (int k = 0; k < N_SIDS; k++) begin
            if (cs[k]) begin
                sel_idx   = IdxW'(k);
                sel_count = sel_count + 3'd1;
            end
        end
    end

    assign sel_valid = (sel_count == 3'd1);
    assign sel_multi = (sel_count > 3'd1);
    assign addr_ro   = (addr >= RoBase) && (addr <= RoBase + 5'd3);
    assign addr_wo   = (addr < 5'(NumWoRegs));
    assign ro_sub    = 2'(addr - RoBase);
    assign read_hit  = sel_valid && oe && addr_ro;
    assign wr_en     = sel_valid && we;
`ifdef SID_REG_READBACK_EN
    assign rd_back   = sel_valid && oe && addr_wo;
`else
    assign rd_back   = 1'b0;
`endif
    assign latch_rd  = read_hit || rd_back;

    always_comb begin
        data_d = '0;
        if (read_hit) begin
            data_d = ro_bytes[sel_idx][ro_sub];
`ifdef SID_REG_READBACK_EN
        end else if (rd_back) begin
            data_d = regs[sel_idx][addr];
`endif
        end else if (sel_valid) begin
            data_d = bus_vals[sel_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            data_o <= '0;
            cs_err <= 1'b0;
            for (int k = 0; k < N_SIDS; k++) begin
                for (int a = 0; a < NumWoRegs; a++) begin
                    regs[k][a] <= '0;
                end
            end
        end else begin
            data_o <= data_d;
            if (phi2) begin
                cs_err <= sel_multi;
                if (wr_en && addr_wo) begin
                    regs[sel_idx][addr] <= data_i;
                end
            end
        end
    end

    for (genvar k = 0; k < N_SIDS; k++) begin : g_bank
        for (genvar a = 0; a < NumWoRegs; a++) begin : g_wo
            assign wo_regs[200*k+8*a +: 8] = regs[k][a];
        end
        for (genvar b = 0; b < NumRoRegs; b++) begin : g_ro
            assign ro_bytes[k][b] = ro_regs[32*k+8*b +: 8];
        end

        // Writes win over reads for the bus latch when both strobes hit.
        sid_bus_fade #(
            .TTL_MOS6581 (TTL_MOS6581),
            .TTL_MOS8580 (TTL_MOS8580)
        ) u_fade (
            .clk        (clk),
            .res_n      (res_n),
            .phi2       (phi2),
            .model      (model[k]),
            .load       (phi2 && sel_valid && (sel_idx == IdxW'(k)) && (wr_en || latch_rd)),
            .load_value (wr_en ? data_i : data_o),
            .bus_value  (bus_vals[k])
        );
    end

endmodule
